// File: rtl/mem_bus_responder.sv
// Memory-side responder for the ADDR/DOUT/W_D processor bus.
// It serves RAM and LED/hex register reads with a fixed two-cycle latency and commits posted writes.
module mem_bus_responder #(
    parameter string INIT_FILE = ""
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       addr_ld,
    input  logic [8:0] addr_i,
    input  logic       wdata_ld,
    input  logic [8:0] wdata_i,
    input  logic       wr,
    output logic [8:0] din,
    output logic       din_valid,
    output logic       busy,
    output logic [8:0] led,
    output logic [8:0] hex,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, WR, RD_ACC, RD_OUT} state_t;

    typedef struct packed {
        logic [8:0] addr;
        logic [8:0] data;
    } wreq_t;

    localparam logic [1:0] MAP_RAM = 2'b00;
    localparam logic [1:0] MAP_LED = 2'b01;
    localparam logic [1:0] MAP_HEX = 2'b10;
    localparam logic [1:0] MAP_NONE = 2'b11;

    logic [8:0] ram [0:127];

    state_t     state, state_nx;
    logic [8:0] addr_q, wdata_q;
    wreq_t      wreq;
    logic       pend_wr, pend_rd;
    logic [8:0] rd_data;
    logic       rd_done, wr_commit;
    logic       wr_drop, wr_unmapped, rd_unmapped;
    logic [1:0] err_inc;
    logic [8:0] err_sum;

    // A write pulse in IDLE goes straight to WR so the commit lands one cycle after W_D.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pend_wr || wr)           state_nx = WR;
                     else if (pend_rd || addr_ld) state_nx = RD_ACC;
            WR:      if (pend_rd || addr_ld)      state_nx = RD_ACC;
                     else                         state_nx = IDLE;
            RD_ACC:  if (addr_ld)                 state_nx = RD_ACC;
                     else                         state_nx = RD_OUT;
            RD_OUT:  if (pend_wr)                 state_nx = WR;
                     else if (addr_ld)            state_nx = RD_ACC;
                     else                         state_nx = IDLE;
            default:                              state_nx = IDLE;
        endcase
    end

    always_comb begin
        rd_data = '0;
        case (addr_q[8:7])
            MAP_RAM: rd_data = ram[addr_q[6:0]];
            MAP_LED: rd_data = led;
            MAP_HEX: rd_data = hex;
            default: rd_data = '0;
        endcase
    end

    assign rd_done     = (state == RD_ACC) && !addr_ld;
    assign wr_commit   = (state == WR);
    assign wr_drop     = wr && pend_wr;
    assign wr_unmapped = wr_commit && (wreq.addr[8:7] == MAP_NONE);
    assign rd_unmapped = rd_done && (addr_q[8:7] == MAP_NONE);
    assign err_inc     = {1'b0, wr_drop} + {1'b0, wr_unmapped} + {1'b0, rd_unmapped};
    assign err_sum     = {1'b0, err_cnt} + {7'd0, err_inc};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            busy      <= 1'b0;
            din_valid <= 1'b0;
            din       <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wreq      <= '0;
            pend_wr   <= 1'b0;
            pend_rd   <= 1'b0;
            led       <= '0;
            hex       <= '0;
            err_cnt   <= '0;
        end else begin
            state     <= state_nx;
            busy      <= (state_nx == WR) || (state_nx == RD_ACC);
            din_valid <= (state_nx == RD_OUT);
            if (addr_ld)  addr_q  <= addr_i;
            if (wdata_ld) wdata_q <= wdata_i;
            // The posted write takes the pre-load bus registers, even if they reload this edge.
            if (wr_commit) pend_wr <= 1'b0;
            if (wr && !pend_wr) begin
                wreq    <= '{addr: addr_q, data: wdata_q};
                pend_wr <= 1'b1;
            end
            if (state == RD_ACC) pend_rd <= addr_ld;
            else if (addr_ld)    pend_rd <= 1'b1;
            if (rd_done) din <= rd_data;
            if (wr_commit && wreq.addr[8:7] == MAP_LED) led <= wreq.data;
            if (wr_commit && wreq.addr[8:7] == MAP_HEX) hex <= wreq.data;
            err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_commit && wreq.addr[8:7] == MAP_RAM)
            ram[wreq.addr[6:0]] <= wreq.data;
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: directed scenarios plus random bus traffic,
// checked every cycle against a transaction-level model of the responder.
module tb_mem_bus_responder;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       addr_ld = 1'b0, wdata_ld = 1'b0, wr = 1'b0;
    logic [8:0] addr_i = '0, wdata_i = '0;
    logic [8:0] din, led, hex;
    logic       din_valid, busy;
    logic [7:0] err_cnt;

    int checks = 0;
    int failures = 0;

    mem_bus_responder dut (
        .clk(clk), .resetn(resetn),
        .addr_ld(addr_ld), .addr_i(addr_i),
        .wdata_ld(wdata_ld), .wdata_i(wdata_i),
        .wr(wr),
        .din(din), .din_valid(din_valid), .busy(busy),
        .led(led), .hex(hex), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Model: what the responder is doing this cycle
    localparam int M_IDLE = 0, M_WRITE = 1, M_ACCESS = 2, M_OUTPUT = 3;
    int         m_act = M_IDLE;
    logic [8:0] m_addr = '0, m_wdata = '0, m_wa = '0, m_wd = '0;
    bit         m_wpost = 0, m_rwant = 0;
    logic [8:0] m_din = '0, m_led = '0, m_hex = '0;
    bit         m_dknown = 1;
    int         m_err = 0;
    logic [8:0] mram [128];
    bit         mknown [128];
    int         nxt, inc, region;
    bit         write_waiting, read_waiting;

    initial begin
        foreach (mknown[i]) mknown[i] = 0;
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                m_act = M_IDLE; m_addr = '0; m_wdata = '0; m_wpost = 0; m_rwant = 0;
                m_din = '0; m_dknown = 1; m_led = '0; m_hex = '0; m_err = 0;
            end else begin
                inc = 0;
                write_waiting = m_wpost || (m_act == M_IDLE && wr);
                read_waiting  = m_rwant || addr_ld;
                // Writes win over reads; a new address during the access restarts it.
                if (m_act == M_ACCESS)      nxt = addr_ld ? M_ACCESS : M_OUTPUT;
                else if (m_act == M_WRITE)  nxt = read_waiting ? M_ACCESS : M_IDLE;
                else if (write_waiting)     nxt = M_WRITE;
                else if (m_act == M_OUTPUT) nxt = addr_ld ? M_ACCESS : M_IDLE;
                else                        nxt = read_waiting ? M_ACCESS : M_IDLE;

                if (m_act == M_ACCESS && !addr_ld) begin
                    region = int'(m_addr >> 7);
                    m_dknown = 1;
                    case (region)
                        0: begin m_din = mram[m_addr % 128]; m_dknown = mknown[m_addr % 128]; end
                        1: m_din = m_led;
                        2: m_din = m_hex;
                        default: begin m_din = '0; inc++; end
                    endcase
                end
                if (m_act == M_WRITE) begin
                    region = int'(m_wa >> 7);
                    case (region)
                        0: begin mram[m_wa % 128] = m_wd; mknown[m_wa % 128] = 1; end
                        1: m_led = m_wd;
                        2: m_hex = m_wd;
                        default: inc++;
                    endcase
                    m_wpost = 0;
                end
                if (wr) begin
                    if (m_act == M_WRITE || !m_wpost) begin
                        if (m_act == M_WRITE) inc++;
                        else begin m_wa = m_addr; m_wd = m_wdata; m_wpost = 1; end
                    end else inc++;
                end
                if (m_act == M_ACCESS) m_rwant = addr_ld;
                else if (addr_ld)      m_rwant = 1;
                if (addr_ld)  m_addr  = addr_i;
                if (wdata_ld) m_wdata = wdata_i;
                m_err = (m_err + inc > 255) ? 255 : m_err + inc;
                m_act = nxt;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            chk("din_valid", 32'(din_valid), 32'(m_act == M_OUTPUT));
            chk("busy", 32'(busy), 32'(m_act == M_WRITE || m_act == M_ACCESS));
            chk("led", 32'(led), 32'(m_led));
            chk("hex", 32'(hex), 32'(m_hex));
            chk("err_cnt", 32'(err_cnt), 32'(m_err));
            if (m_dknown) chk("din", 32'(din), 32'(m_din));
        end
    end

    task automatic step(input bit a, input logic [8:0] ai, input bit w, input logic [8:0] wi, input bit wrr);
        addr_ld = a; addr_i = ai; wdata_ld = w; wdata_i = wi; wr = wrr;
        @(posedge clk); #1;
        addr_ld = 0; wdata_ld = 0; wr = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, '0, 0);
    endtask

    task automatic wr_word(input logic [8:0] a, input logic [8:0] d);
        step(1, a, 1, d, 0);
        idle(3);
        step(0, '0, 0, '0, 1);
        idle(2);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_din", 32'(din), 0);
        chk("rst_din_valid", 32'(din_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_led", 32'(led), 0);
        chk("rst_hex", 32'(hex), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
    endtask

    logic [8:0] save_led, save_hex;
    int         r;
    logic [8:0] ra;

    initial begin
        repeat (3) @(posedge clk);
        #1 resetn = 1;
        chk_reset_outputs();

        // Two-cycle read latency
        wr_word(9'h005, 9'h1A3);
        step(1, 9'h005, 0, '0, 0);
        chk("rd_c1_busy", 32'(busy), 1);
        chk("rd_c1_valid", 32'(din_valid), 0);
        idle(1);
        chk("rd_c2_valid", 32'(din_valid), 1);
        chk("rd_c2_din", 32'(din), 32'h1A3);
        idle(1);
        chk("rd_c3_valid", 32'(din_valid), 0);
        chk("rd_c3_hold", 32'(din), 32'h1A3);
        idle(1);

        // LED write and read-back
        step(1, 9'h080, 1, 9'h055, 0);
        idle(3);
        step(0, '0, 0, '0, 1);
        chk("led_wr_c1_busy", 32'(busy), 1);
        chk("led_wr_c1_old", 32'(led), 0);
        idle(1);
        chk("led_wr_c2", 32'(led), 32'h055);
        step(1, 9'h080, 0, '0, 0);
        idle(1);
        chk("led_rd_din", 32'(din), 32'h055);
        idle(2);

        // Write and read issued together
        step(1, 9'h003, 1, 9'h011, 0);
        idle(3);
        step(1, 9'h003, 0, '0, 1);
        chk("wr_rd_c1_busy", 32'(busy), 1);
        idle(1);
        chk("wr_rd_c2_valid", 32'(din_valid), 0);
        idle(1);
        chk("wr_rd_c3_valid", 32'(din_valid), 1);
        chk("wr_rd_c3_din", 32'(din), 32'h011);
        idle(2);

        // Aborted read
        wr_word(9'h010, 9'h0F0);
        wr_word(9'h011, 9'h10F);
        step(1, 9'h010, 0, '0, 0);
        step(1, 9'h011, 0, '0, 0);
        chk("abort_c2_valid", 32'(din_valid), 0);
        idle(1);
        chk("abort_c3_valid", 32'(din_valid), 1);
        chk("abort_c3_din", 32'(din), 32'h10F);
        idle(1);
        chk("abort_c4_valid", 32'(din_valid), 0);
        idle(1);

        // Second write while one is posted
        step(1, 9'h020, 1, 9'h0AA, 0);
        idle(3);
        chk("drop_err_before", 32'(err_cnt), 0);
        step(1, 9'h020, 0, '0, 0);
        step(0, '0, 1, 9'h0BB, 1);
        step(0, '0, 0, '0, 1);
        idle(1);
        chk("drop_err_after", 32'(err_cnt), 1);
        step(1, 9'h020, 0, '0, 0);
        idle(1);
        chk("drop_first_kept", 32'(din), 32'h0AA);
        idle(2);

        // Reset in the middle of a write
        step(0, '0, 0, '0, 1);
        chk("mid_wr_busy", 32'(busy), 1);
        resetn = 0;
        #1;
        chk_reset_outputs();
        @(posedge clk); #1;
        resetn = 1;
        step(1, 9'h020, 0, '0, 0);
        idle(1);
        chk("post_rst_ram", 32'(din), 32'h0AA);
        idle(2);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 15);
            if (r < 11)      ra = 9'($urandom_range(0, 15));
            else if (r < 13) ra = 9'h080 | 9'($urandom_range(0, 127));
            else if (r < 15) ra = 9'h100 | 9'($urandom_range(0, 127));
            else             ra = 9'h180 | 9'($urandom_range(0, 127));
            step(($urandom_range(0, 9) < 3), ra, ($urandom_range(0, 9) < 3),
                 9'($urandom_range(0, 511)), ($urandom_range(0, 19) < 3));
        end
        idle(6);

        // Unmapped reads saturate the error counter
        for (int i = 0; i < 300; i++) begin
            step(1, 9'h1C0, 0, '0, 0);
            idle(1);
            chk("unmapped_valid", 32'(din_valid), 1);
            chk("unmapped_din", 32'(din), 0);
        end
        idle(2);
        chk("err_saturated", 32'(err_cnt), 255);

        save_led = m_led;
        save_hex = m_hex;
        wr_word(9'h1FF, 9'h123);
        chk("unmapped_wr_led", 32'(led), 32'(save_led));
        chk("unmapped_wr_hex", 32'(hex), 32'(save_hex));
        chk("err_still_sat", 32'(err_cnt), 255);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
